// File: rtl/noc_params.sv
// Router-wide parameters shared by the NoC blocks: port count, index width and port_t.
package noc_params;

  localparam int PORT_NUM  = 5;
  localparam int PORT_SIZE = $clog2(PORT_NUM);

  typedef logic [PORT_SIZE-1:0] port_t;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter for one output port: priority pointer, one-hot grant and encoded index.
// With SA_PACKET_LOCK_EN the output stays locked to a packet owner until its tail flit.
module rr_arbiter
  import noc_params::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PORT_NUM-1:0] request_i,
  input  logic                enable_i,
`ifdef SA_PACKET_LOCK_EN
  input  logic [PORT_NUM-1:0] tail_i,
`endif
  output logic [PORT_NUM-1:0] grant_o,
  output port_t               grant_idx_o,
  output logic                grant_valid_o
);

  localparam logic [PORT_SIZE:0]    NUM_W  = (PORT_SIZE+1)'(PORT_NUM);
  localparam logic [PORT_NUM-1:0]   ONE_HOT0 = {{(PORT_NUM-1){1'b0}}, 1'b1};

  port_t               ptr_q, ptr_d;
  logic [PORT_NUM-1:0] req_eff;
  port_t               win;
  port_t               win_next;
  logic                found;
  logic                win_tail;

`ifdef SA_PACKET_LOCK_EN
  logic  lock_valid_q, lock_valid_d;
  port_t lock_owner_q, lock_owner_d;

  // A held lock masks every candidate except the packet owner.
  always_comb begin
    req_eff = request_i;
    if (lock_valid_q) req_eff = request_i & (ONE_HOT0 << lock_owner_q);
  end
  assign win_tail = tail_i[win];
`else
  assign req_eff  = request_i;
  assign win_tail = 1'b1;
`endif

  always_comb begin
    logic [PORT_SIZE:0] sum;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      sum = {1'b0, ptr_q} + (PORT_SIZE+1)'(k);
      if (sum >= NUM_W) sum = sum - NUM_W;
      if (!found && req_eff[port_t'(sum)]) begin
        found = 1'b1;
        win   = port_t'(sum);
      end
    end
  end

  assign grant_valid_o = enable_i && found && !rst;
  assign grant_o       = grant_valid_o ? (ONE_HOT0 << win) : '0;
  assign grant_idx_o   = grant_valid_o ? win : '0;

  assign win_next = (win == port_t'(PORT_NUM-1)) ? '0 : win + port_t'(1);

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid_o && win_tail) ptr_d = win_next;
  end

`ifdef SA_PACKET_LOCK_EN
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (grant_valid_o) begin
      if (win_tail) begin
        lock_valid_d = 1'b0;
        lock_owner_d = '0;
      end else begin
        lock_valid_d = 1'b1;
        lock_owner_d = win;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator: request decode, one rr_arbiter per output, grant merge.
// Optional packet-level locking is enabled with SA_PACKET_LOCK_EN.
module switch_allocator
  import noc_params::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUM-1:0]           switch_request,
  input  logic [PORT_NUM*PORT_SIZE-1:0] out_port,
  input  logic [PORT_NUM-1:0]           tail_flit,
  input  logic [PORT_NUM-1:0]           downstream_ready,
  output logic [PORT_NUM-1:0]           valid_sel,
  output logic [PORT_NUM*PORT_SIZE-1:0] xbar_sel,
  output logic [PORT_NUM-1:0]           xbar_valid
);

  logic [PORT_NUM-1:0] req   [PORT_NUM];
  logic [PORT_NUM-1:0] grant [PORT_NUM];
  port_t               idx   [PORT_NUM];

`ifndef SA_PACKET_LOCK_EN
  logic unused_tail;
  assign unused_tail = ^tail_flit;
`endif

  // Out-of-range port values compare unequal to every output and so never win.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      req[o] = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        req[o][i] = switch_request[i] &&
                    (out_port[i*PORT_SIZE +: PORT_SIZE] == port_t'(o));
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : gen_arb
    rr_arbiter u_arb (
      .clk           (clk),
      .rst           (rst),
      .request_i     (req[o]),
      .enable_i      (downstream_ready[o]),
`ifdef SA_PACKET_LOCK_EN
      .tail_i        (tail_flit),
`endif
      .grant_o       (grant[o]),
      .grant_idx_o   (idx[o]),
      .grant_valid_o (xbar_valid[o])
    );
    assign xbar_sel[o*PORT_SIZE +: PORT_SIZE] = idx[o];
  end

  always_comb begin
    valid_sel = '0;
    for (int o = 0; o < PORT_NUM; o++) valid_sel = valid_sel | grant[o];
  end

endmodule
